// File: rtl/led_game_pkg.sv
// Shared game-timing definitions: phase state encoding and board clock rate.
// Used by the round sequencer and any other millisecond-timed block.
package led_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } game_state_e;

    localparam int DEFAULT_CLKS_PER_MS = 50000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_round_sequencer_if.sv
// Control/status bundle between the game controller and the round sequencer.
// slave = sequencer side, master = controller / key and display side.
interface led_round_sequencer_if #(
    parameter int NUM_LEDS   = 10,
    parameter int NUM_ROUNDS = 10
);
    localparam int IDX_W = $clog2(NUM_ROUNDS + 1);

    logic                start;
    logic                abort;
    logic [NUM_LEDS-1:0] enable;
    logic [IDX_W-1:0]    round_idx;
    logic                busy;
    logic                done;

    modport slave (
        input  start,
        input  abort,
        output enable,
        output round_idx,
        output busy,
        output done
    );

    modport master (
        output start,
        output abort,
        input  enable,
        input  round_idx,
        input  busy,
        input  done
    );

endinterface

// File: rtl/led_round_sequencer_ms_tick.sv
// ms_tick_gen: one-cycle tick every CLKS_PER_MS cycles, phase restarted by clear.
// Reusable by any block that needs a millisecond time base.
module ms_tick_gen
    import led_game_pkg::*;
#(
    parameter int CLKS_PER_MS = DEFAULT_CLKS_PER_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int             CW   = width_for(CLKS_PER_MS);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick comes from the registered count only, so clear can depend on it.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_round_sequencer.sv
// Round sequencer: ON window / OFF gap per round, then a one-cycle done pulse.
// Optional LED_ROUND_SPEEDUP_EN shortens the ON window each round down to MIN_ON_MS.
module led_round_sequencer
    import led_game_pkg::*;
#(
    parameter int CLKS_PER_MS = DEFAULT_CLKS_PER_MS,
    parameter int ON_MS       = 1000,
    parameter int OFF_MS      = 500,
    parameter int NUM_ROUNDS  = 10,
    parameter int NUM_LEDS    = 10
`ifdef LED_ROUND_SPEEDUP_EN
    ,
    parameter int SPEEDUP_MS  = 50,
    parameter int MIN_ON_MS   = 200
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_round_sequencer_if.slave   bus
);
`ifdef LED_ROUND_SPEEDUP_EN
    localparam int MS_MAX = max_int(max_int(ON_MS, OFF_MS), MIN_ON_MS);
`else
    localparam int MS_MAX = max_int(ON_MS, OFF_MS);
`endif
    localparam int MSW   = $clog2(MS_MAX + 1);
    localparam int IDX_W = $clog2(NUM_ROUNDS + 1);

    localparam logic [MSW-1:0]   OFF_LAST   = MSW'(OFF_MS - 1);
    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NUM_ROUNDS);

    game_state_e      state_q,  state_d;
    logic             start_q;
    logic [MSW-1:0]   ms_q,     ms_d;
    logic [IDX_W-1:0] round_q,  round_d;
    logic             enable_q, enable_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             start_rise;
    logic             tick;
    logic             tick_clear;
    logic             expire;
    logic [MSW-1:0]   on_last;
    logic [MSW-1:0]   phase_last;

    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

`ifdef LED_ROUND_SPEEDUP_EN
    logic signed [31:0] on_ms_s;

    // Signed so late rounds go negative instead of wrapping, then clamp.
    always_comb begin
        on_ms_s = ON_MS - (int'(round_q) - 1) * SPEEDUP_MS;
        if (on_ms_s < MIN_ON_MS) begin
            on_ms_s = MIN_ON_MS;
        end
        on_last = MSW'(on_ms_s - 1);
    end
`else
    assign on_last = MSW'(ON_MS - 1);
`endif

    assign start_rise = bus.start & ~start_q;
    assign phase_last = (state_q == ST_ON) ? on_last : OFF_LAST;
    // The phase ends on the tick that brings the ms count up to its length.
    assign expire     = tick && (ms_q == phase_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise && !bus.abort) begin
                    state_d = ST_ON;
                    round_d = IDX_W'(1);
                end
            end
            ST_ON: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = (round_q < LAST_ROUND) ? ST_OFF : ST_DONE;
                end
            end
            ST_OFF: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_ON;
                    round_d = round_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tick_clear = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE);

        ms_d = ms_q;
        if (tick_clear) begin
            ms_d = '0;
        end else if (tick) begin
            ms_d = ms_q + 1'b1;
        end

        // Outputs are registered copies of what the next state implies.
        enable_d = (state_d == ST_ON);
        busy_d   = (state_d == ST_ON) || (state_d == ST_OFF);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            ms_q     <= '0;
            round_q  <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q  <= bus.start;
            ms_q     <= ms_d;
            round_q  <= round_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_enable
        assign bus.enable[gi] = enable_q;
    end

    assign bus.round_idx = round_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_led_round_sequencer.sv
// Scoreboard bench for led_round_sequencer: a timeline reference model queues the
// expected outputs per clock; a negedge monitor pops and compares them.
module tb_led_round_sequencer;
    import led_game_pkg::*;

    localparam int C    = 4;
    localparam int ON   = 2;
    localparam int OFF  = 1;
    localparam int NR   = 3;
    localparam int NL   = 10;
    localparam int IW   = $clog2(NR + 1);
`ifdef LED_ROUND_SPEEDUP_EN
    localparam int SP       = 1;
    localparam int MINON    = 1;
    localparam int EXP_DONE = 25;
`else
    localparam int EXP_DONE = 33;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_round_sequencer_if #(.NUM_LEDS(NL), .NUM_ROUNDS(NR)) bus ();

    led_round_sequencer #(
        .CLKS_PER_MS (C),
        .ON_MS       (ON),
        .OFF_MS      (OFF),
        .NUM_ROUNDS  (NR),
        .NUM_LEDS    (NL)
`ifdef LED_ROUND_SPEEDUP_EN
        ,
        .SPEEDUP_MS  (SP),
        .MIN_ON_MS   (MINON)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NL-1:0] en;
        logic [IW-1:0] rnd;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_cyc = -1;

    // Reference model state: position within the game timeline.
    bit   in_game = 0;
    int   pos = 0;
    int   held_round = 0;
    bit   start_prev = 0;

    function automatic int on_cycles(input int r);
`ifdef LED_ROUND_SPEEDUP_EN
        return max_int(ON - (r - 1) * SP, MINON) * C;
`else
        return ON * C + 0 * r;
`endif
    endfunction

    // Game laid out as ON(1) OFF ON(2) OFF ... ON(NR) DONE, offset 0 = first ON cycle.
    task automatic timeline(input int o, output bit b, output bit on, output bit d, output int rnd);
        int acc;
        acc = 0; b = 0; on = 0; d = 0; rnd = NR;
        for (int r = 1; r <= NR; r++) begin
            if (b) continue;
            if (o < acc + on_cycles(r)) begin
                b = 1; on = 1; rnd = r;
                continue;
            end
            acc += on_cycles(r);
            if (r < NR) begin
                if (o < acc + OFF * C) begin
                    b = 1; rnd = r;
                    continue;
                end
                acc += OFF * C;
            end
        end
        if (!b && o == acc) d = 1;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit in_reset);
        bit   rise, b, on, d;
        int   r;
        obs_t e;
        if (in_reset) begin
            in_game = 0; held_round = 0; start_prev = 0;
        end else begin
            rise = s && !start_prev;
            start_prev = s;
            if (in_game) begin
                timeline(pos, b, on, d, r);
                if ((b && a) || d) in_game = 0;
                else pos++;
            end else if (rise && !a) begin
                in_game = 1; pos = 0;
            end
        end
        e = '0;
        e.rnd = IW'(held_round);
        if (in_game) begin
            timeline(pos, b, on, d, r);
            held_round = r;
            e.en   = on ? {NL{1'b1}} : '0;
            e.rnd  = IW'(r);
            e.busy = b;
            e.done = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit s, input bit a);
        bus.start = s;
        bus.abort = a;
        @(posedge clk);
        cyc++;
        model_edge(s, a, !rst_n);
        @(negedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare against the queued model value.
    initial begin
        obs_t e;
        obs_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.enable, bus.round_idx, bus.busy, bus.done};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got en=%h rnd=%0d busy=%b done=%b, expected en=%h rnd=%0d busy=%b done=%b",
                             cyc, act.en, act.rnd, act.busy, act.done, e.en, e.rnd, e.busy, e.done);
                end
                if (bus.done === 1'b1) begin
                    done_seen++;
                    done_cyc = cyc;
                    $display("game done: cycle %0d round_idx %0d", cyc, bus.round_idx);
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #12;
        check_eq("reset_outputs", int'({bus.enable, bus.round_idx, bus.busy, bus.done}), 0);
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 0);

        $display("scenario: normal game");
        cyc = 0; done_seen = 0; done_cyc = -1;
        step(1, 0);
        repeat (39) step(0, 0);
        check_eq("normal_done_count", done_seen, 1);
        check_eq("normal_done_cycle", done_cyc, EXP_DONE);
        check_eq("normal_round_hold", int'(bus.round_idx), NR);

        $display("scenario: start while busy");
        cyc = 0; done_seen = 0; done_cyc = -1;
        step(1, 0);
        for (int i = 1; i < 40; i++) step(i == 10, 0);
        check_eq("busy_start_done_count", done_seen, 1);
        check_eq("busy_start_done_cycle", done_cyc, EXP_DONE);

        $display("scenario: held start");
        done_seen = 0;
        repeat (100) step(1, 0);
        repeat (5) step(0, 0);
        check_eq("held_done_count", done_seen, 1);
        step(1, 0);
        step(0, 0);
        check_eq("restart_round", int'(bus.round_idx), 1);
        repeat (40) step(0, 0);

        $display("scenario: abort mid-ON");
        cyc = 0; done_seen = 0;
        step(1, 0);
        repeat (4) step(0, 0);
        step(0, 1);
        check_eq("abort_busy", int'(bus.busy), 0);
        check_eq("abort_round", int'(bus.round_idx), 1);
        step(1, 1);
        step(0, 0);
        step(1, 0);
        repeat (3) step(0, 0);
        step(1, 1);
        step(0, 0);
        step(0, 1);
        step(1, 1);
        repeat (40) step(0, 0);
        check_eq("abort_no_done", done_seen, 0);

        $display("scenario: async reset mid-OFF");
        cyc = 0;
        step(1, 0);
        repeat (21) step(0, 0);
        check_eq("pre_reset_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", int'({bus.enable, bus.round_idx, bus.busy, bus.done}), 0);
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 0);
        check_eq("post_reset_round", int'(bus.round_idx), 0);

        $display("scenario: random");
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
        end
        step(0, 0);
        step(0, 0);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
